// File: rtl/hetero_phase_gen.sv
// hetero_phase_gen: streaming source of three wrapped fringe phases plus the
// true unwrapped phase1, laid out as a linear phase ramp per line. The three
// per-pixel steps are derived from one captured step so the frequency ratios
// match the heterodyne unwrapper exactly.
//
// Handshake: a beat transfers when vld_o && rdy_i. While rdy_i is low every
// output holds. After a transfer the next pixel appears on the next cycle,
// and vld_o stays high from pixel (0,0) until the last pixel of the frame
// has transferred.
module hetero_phase_gen #(
  parameter int DATA_WIDTH = 24,
  parameter int ABS_WIDTH  = 32,
  parameter int RATIO_3TO2 = 8,
  parameter int RATIO_2TO1 = 8,
  parameter int IMG_W      = 1280,
  parameter int IMG_H      = 1024,
  parameter int PI_2       = 51471
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] step_i,
  input  logic                  rdy_i,
  output logic                  vld_o,
  output logic [DATA_WIDTH-1:0] phase1_o,
  output logic [DATA_WIDTH-1:0] phase2_o,
  output logic [DATA_WIDTH-1:0] phase3_o,
  output logic [ABS_WIDTH-1:0]  abs_phase_o,
  output logic                  sof_o,
  output logic                  tlast_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam int LOG2_R21  = $clog2(RATIO_2TO1);
  localparam int LOG2_RALL = $clog2(RATIO_2TO1 * RATIO_3TO2);
  localparam int X_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int Y_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [DATA_WIDTH-1:0] PI_D   = DATA_WIDTH'(PI_2);
  localparam logic [DATA_WIDTH:0]   PI_S   = (DATA_WIDTH+1)'(PI_2);
  localparam logic [X_W-1:0]        X_LAST = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0]        Y_LAST = Y_W'(IMG_H - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] step1_q, step2_q, step3_q;
  logic [DATA_WIDTH-1:0] acc1_q, acc2_q, acc3_q;
  logic [ABS_WIDTH-1:0]  abs_q;
  logic [X_W-1:0]        x_q;
  logic [Y_W-1:0]        y_q;
  logic                  err_q;

  logic step_ok, start_acc, xfer, line_end, frame_end;

  // A step is usable only if it is nonzero, below 2*pi and divisible by the
  // combined ratio so the derived steps are exact.
  assign step_ok   = (step_i != '0) && (step_i < PI_D) &&
                     (step_i[LOG2_RALL-1:0] == '0);
  assign start_acc = (state_q == S_IDLE) && start_i && step_ok;
  assign xfer      = (state_q == S_RUN) && rdy_i;
  assign line_end  = (x_q == X_LAST);
  assign frame_end = line_end && (y_q == Y_LAST);

  // Modular add; a single conditional subtract suffices since step < 2*pi.
  function automatic logic [DATA_WIDTH-1:0] wrap_add(
    input logic [DATA_WIDTH-1:0] acc,
    input logic [DATA_WIDTH-1:0] step
  );
    logic [DATA_WIDTH:0] s;
    s = {1'b0, acc} + {1'b0, step};
    if (s >= PI_S) s = s - PI_S;
    return s[DATA_WIDTH-1:0];
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_acc) state_d = S_RUN;
      S_RUN:   if (xfer && frame_end) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Step capture, phase accumulators, absolute phase and pixel counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step1_q <= '0;
      step2_q <= '0;
      step3_q <= '0;
      acc1_q  <= '0;
      acc2_q  <= '0;
      acc3_q  <= '0;
      abs_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else if (start_acc) begin
      step1_q <= step_i;
      step2_q <= step_i - (step_i >> LOG2_RALL);
      step3_q <= step_i - (step_i >> LOG2_R21);
      acc1_q  <= '0;
      acc2_q  <= '0;
      acc3_q  <= '0;
      abs_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else if (xfer) begin
      if (line_end) begin
        // Every line restarts at phase 0.
        acc1_q <= '0;
        acc2_q <= '0;
        acc3_q <= '0;
        abs_q  <= '0;
        x_q    <= '0;
        y_q    <= (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        acc1_q <= wrap_add(acc1_q, step1_q);
        acc2_q <= wrap_add(acc2_q, step2_q);
        acc3_q <= wrap_add(acc3_q, step3_q);
        abs_q  <= abs_q + ABS_WIDTH'(step1_q);
        x_q    <= x_q + 1'b1;
      end
    end
  end

  // Rejected start request pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= (state_q == S_IDLE) && start_i && !step_ok;
  end

  assign vld_o       = (state_q == S_RUN);
  assign busy_o      = (state_q == S_RUN);
  assign done_o      = (state_q == S_DONE);
  assign sof_o       = vld_o && (x_q == '0) && (y_q == '0);
  assign tlast_o     = vld_o && line_end;
  assign phase1_o    = acc1_q;
  assign phase2_o    = acc2_q;
  assign phase3_o    = acc3_q;
  assign abs_phase_o = abs_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_hetero_phase_gen.sv
// Directed bench for hetero_phase_gen with an 8x2 frame.
module tb_hetero_phase_gen;

  localparam int PI2 = 51471;
  localparam int W   = 8;
  localparam int H   = 2;
  localparam int NB  = W * H;

  logic        clk, rst_n, start_i, rdy_i;
  logic [23:0] step_i;
  logic        vld_o, sof_o, tlast_o, busy_o, done_o, err_o;
  logic [23:0] phase1_o, phase2_o, phase3_o;
  logic [31:0] abs_phase_o;

  int n_cmp  = 0;
  int n_fail = 0;

  hetero_phase_gen #(
    .DATA_WIDTH(24), .ABS_WIDTH(32), .RATIO_3TO2(8), .RATIO_2TO1(8),
    .IMG_W(W), .IMG_H(H), .PI_2(PI2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .step_i(step_i),
    .rdy_i(rdy_i), .vld_o(vld_o), .phase1_o(phase1_o), .phase2_o(phase2_o),
    .phase3_o(phase3_o), .abs_phase_o(abs_phase_o), .sof_o(sof_o),
    .tlast_o(tlast_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  // Clock and reset defaults.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a start request for one cycle; returns #1 after the sampling edge.
  task automatic do_start(input int step);
    start_i = 1'b1;
    step_i  = 24'(step);
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_i = 1'b0; rdy_i = 1'b1; step_i = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({vld_o, sof_o, tlast_o, busy_o, done_o, err_o} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags got=%b want=000000",
               {vld_o, sof_o, tlast_o, busy_o, done_o, err_o});
    end
    n_cmp++;
    if ({phase1_o, phase2_o, phase3_o, abs_phase_o} !== 104'b0) begin
      n_fail++;
      $display("FAIL reset_data p1=%0d p2=%0d p3=%0d abs=%0d want all 0",
               phase1_o, phase2_o, phase3_o, abs_phase_o);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Run one full frame with rdy_i=1, checking every beat against x*step mod 2*pi.
  // inject_at >= 0 pulses a second start request during the frame.
  task automatic run_frame(input int step, input int inject_at);
    int s2, s3, b, x;
    logic [23:0] e1, e2, e3;
    logic [31:0] ea;
    s2 = step - step / 64;
    s3 = step - step / 8;
    rdy_i = 1'b1;
    do_start(step);
    b = 0;
    for (int cyc = 0; cyc < 200 && b < NB; cyc++) begin
      n_cmp++;
      if (vld_o !== 1'b1) begin
        n_fail++;
        $display("FAIL frame_vld step=%0d beat=%0d got=%b want=1", step, b, vld_o);
      end else begin
        x  = b % W;
        e1 = 24'((x * step) % PI2);
        e2 = 24'((x * s2) % PI2);
        e3 = 24'((x * s3) % PI2);
        ea = 32'(x * step);
        n_cmp++;
        if (phase1_o !== e1 || phase2_o !== e2 || phase3_o !== e3) begin
          n_fail++;
          $display("FAIL frame_phase step=%0d beat=%0d got=%0d/%0d/%0d want=%0d/%0d/%0d",
                   step, b, phase1_o, phase2_o, phase3_o, e1, e2, e3);
        end
        n_cmp++;
        if (abs_phase_o !== ea) begin
          n_fail++;
          $display("FAIL frame_abs step=%0d beat=%0d got=%0d want=%0d", step, b, abs_phase_o, ea);
        end
        n_cmp++;
        if (sof_o !== (b == 0) || tlast_o !== (x == W - 1)) begin
          n_fail++;
          $display("FAIL frame_flags beat=%0d sof=%b tlast=%b want sof=%b tlast=%b",
                   b, sof_o, tlast_o, (b == 0), (x == W - 1));
        end
        n_cmp++;
        if (busy_o !== 1'b1 || err_o !== 1'b0 || done_o !== 1'b0) begin
          n_fail++;
          $display("FAIL frame_status beat=%0d busy=%b err=%b done=%b want 1/0/0",
                   b, busy_o, err_o, done_o);
        end
        b++;
      end
      start_i = (cyc == inject_at);
      step_i  = (cyc == inject_at) ? 24'd512 : step_i;
      @(posedge clk); #1;
    end
    start_i = 1'b0;
    n_cmp++;
    if (b !== NB) begin
      n_fail++;
      $display("FAIL frame_beats step=%0d got=%0d want=%0d", step, b, NB);
    end
    n_cmp++;
    if (done_o !== 1'b1 || busy_o !== 1'b0 || vld_o !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_done done=%b busy=%b vld=%b want 1/0/0", done_o, busy_o, vld_o);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (done_o !== 1'b0 || busy_o !== 1'b0 || vld_o !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_idle done=%b busy=%b vld=%b want 0/0/0", done_o, busy_o, vld_o);
    end
  endtask

  // Hand-computed vectors for step 8192 (step2=8064, step3=7168).
  task automatic test_known_values();
    int b;
    rdy_i = 1'b1;
    do_start(8192);
    b = 0;
    for (int cyc = 0; cyc < 40 && b < 8; cyc++) begin
      if (vld_o === 1'b1) begin
        if (b == 6) begin
          n_cmp++;
          if (phase1_o !== 24'd49152 || phase2_o !== 24'd48384 || phase3_o !== 24'd43008) begin
            n_fail++;
            $display("FAIL known_px6 got=%0d/%0d/%0d want=49152/48384/43008",
                     phase1_o, phase2_o, phase3_o);
          end
        end
        if (b == 7) begin
          n_cmp++;
          if (phase1_o !== 24'd5873 || phase2_o !== 24'd4977 || phase3_o !== 24'd50176 ||
              abs_phase_o !== 32'd57344 || tlast_o !== 1'b1) begin
            n_fail++;
            $display("FAIL known_px7 got=%0d/%0d/%0d abs=%0d tlast=%b want=5873/4977/50176 abs=57344 tlast=1",
                     phase1_o, phase2_o, phase3_o, abs_phase_o, tlast_o);
          end
        end
        b++;
      end
      @(posedge clk); #1;
    end
    // Beat 8 opens line 1: phases back to zero, no sof.
    n_cmp++;
    if (vld_o !== 1'b1 || phase1_o !== 24'd0 || phase2_o !== 24'd0 || phase3_o !== 24'd0 ||
        abs_phase_o !== 32'd0 || sof_o !== 1'b0) begin
      n_fail++;
      $display("FAIL known_line1 vld=%b got=%0d/%0d/%0d abs=%0d sof=%b want 1,0/0/0,0,0",
               vld_o, phase1_o, phase2_o, phase3_o, abs_phase_o, sof_o);
    end
    // Let the frame finish.
    for (int cyc = 0; cyc < 40 && done_o !== 1'b1; cyc++) begin
      @(posedge clk); #1;
    end
    n_cmp++;
    if (done_o !== 1'b1) begin
      n_fail++;
      $display("FAIL known_done got=%b want=1", done_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int b;
    rdy_i = 1'b1;
    do_start(8192);
    b = 0;
    for (int cyc = 0; cyc < 20 && b < 2; cyc++) begin
      if (vld_o === 1'b1) b++;
      @(posedge clk); #1;
    end
    rdy_i = 1'b0;
    for (int h = 0; h < 3; h++) begin
      n_cmp++;
      if (vld_o !== 1'b1 || phase1_o !== 24'd16384 || phase2_o !== 24'd16128 ||
          phase3_o !== 24'd14336 || abs_phase_o !== 32'd16384) begin
        n_fail++;
        $display("FAIL bp_hold cyc=%0d vld=%b got=%0d/%0d/%0d abs=%0d want 1,16384/16128/14336,16384",
                 h, vld_o, phase1_o, phase2_o, phase3_o, abs_phase_o);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (phase1_o !== 24'd16384) begin
      n_fail++;
      $display("FAIL bp_last_hold got=%0d want=16384", phase1_o);
    end
    rdy_i = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (vld_o !== 1'b1 || phase1_o !== 24'd24576 || phase2_o !== 24'd24192 ||
        phase3_o !== 24'd21504) begin
      n_fail++;
      $display("FAIL bp_px3 vld=%b got=%0d/%0d/%0d want 1,24576/24192/21504",
               vld_o, phase1_o, phase2_o, phase3_o);
    end
    for (int cyc = 0; cyc < 40 && done_o !== 1'b1; cyc++) begin
      @(posedge clk); #1;
    end
    n_cmp++;
    if (done_o !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_done got=%b want=1", done_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_invalid_start();
    int bad [3] = '{51471, 100, 0};
    for (int i = 0; i < 3; i++) begin
      do_start(bad[i]);
      n_cmp++;
      if (err_o !== 1'b1 || busy_o !== 1'b0 || vld_o !== 1'b0) begin
        n_fail++;
        $display("FAIL invalid_pulse step=%0d err=%b busy=%b vld=%b want 1/0/0",
                 bad[i], err_o, busy_o, vld_o);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (err_o !== 1'b0 || busy_o !== 1'b0 || vld_o !== 1'b0) begin
        n_fail++;
        $display("FAIL invalid_after step=%0d err=%b busy=%b vld=%b want 0/0/0",
                 bad[i], err_o, busy_o, vld_o);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int b;
    rdy_i = 1'b1;
    do_start(8192);
    b = 0;
    for (int cyc = 0; cyc < 20 && b < 5; cyc++) begin
      if (vld_o === 1'b1) b++;
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({vld_o, sof_o, tlast_o, busy_o, done_o, err_o} !== 6'b0 ||
        {phase1_o, phase2_o, phase3_o, abs_phase_o} !== 104'b0) begin
      n_fail++;
      $display("FAIL midrst_outputs flags=%b p1=%0d abs=%0d want all 0",
               {vld_o, sof_o, tlast_o, busy_o, done_o, err_o}, phase1_o, abs_phase_o);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (done_o !== 1'b0 || vld_o !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_nodone cyc=%0d done=%b vld=%b want 0/0", i, done_o, vld_o);
      end
    end
    run_frame(8192, -1);
  endtask

  initial begin
    test_reset();
    test_known_values();
    run_frame(8192, -1);
    test_backpressure();
    test_invalid_start();
    run_frame(8192, 3);   // start during RUN is ignored
    run_frame(64, -1);    // smallest valid step
    run_frame(51456, -1); // largest valid step
    run_frame(512, -1);
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
